// File: rtl/decoder_pkg.sv
// Shared types for the one-hot decoder / scan sequencer.
// Pure declarations; no latency, no backpressure.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational IN_W -> 2**IN_W one-hot decoder.
// Zero latency; no backpressure.
module onehot_dec #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]      sel_i,
    output logic [(2**IN_W)-1:0] dec_o
);

    always_comb begin
        dec_o        = '0;
        dec_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with direct-hold and dwell-timed scan modes.
// 1-cycle latency from inputs to all outputs; no backpressure.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int IN_W    = 3,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 load,
    input  logic [IN_W-1:0]      in,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [(2**IN_W)-1:0] out,
    output logic                 out_valid,
    output logic [IN_W-1:0]      idx,
    output logic                 wrap
);

    localparam int OUT_W = 2**IN_W;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic [OUT_W-1:0]   out_q;
    logic               valid_q;
    logic [OUT_W-1:0]   dec;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mode == MODE_SCAN) begin
                        state_d = SCAN;
                        idx_d   = in;
                        cnt_d   = '0;
                    end else if (load) begin
                        state_d = HOLD;
                        idx_d   = in;
                    end
                end
                HOLD: begin
                    if (mode == MODE_SCAN) begin
                        state_d = SCAN;
                        idx_d   = in;
                        cnt_d   = '0;
                    end else if (load) begin
                        idx_d = in;
                    end
                end
                SCAN: begin
                    if (mode == MODE_DIRECT) begin
                        cnt_d = '0;
                        if (load) begin
                            state_d = HOLD;
                            idx_d   = in;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (cnt_q == dwell) begin
                        // A dwell lowered below cnt simply waits for cnt to roll over.
                        cnt_d  = '0;
                        idx_d  = idx_q + 1'b1;
                        wrap_d = (idx_q == {IN_W{1'b1}});
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    onehot_dec #(.IN_W(IN_W)) u_dec (
        .sel_i (idx_d),
        .dec_o (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            out_q   <= (state_d != IDLE) ? dec : '0;
            valid_q <= (state_d != IDLE);
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign idx       = idx_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: vector table plus hand-written corner sequences.
module tb_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, load;
    logic [2:0] in;
    logic [7:0] dwell;
    logic [7:0] out;
    logic       out_valid, wrap;
    logic [2:0] idx;

    logic        en_b, mode_b, load_b;
    logic [3:0]  in_b, idx_b;
    logic [7:0]  dwell_b;
    logic [15:0] out_b;
    logic        out_valid_b, wrap_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decoder_seq dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .in(in), .dwell(dwell), .out(out), .out_valid(out_valid),
        .idx(idx), .wrap(wrap)
    );

    decoder_seq #(.IN_W(4), .DWELL_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .load(load_b),
        .in(in_b), .dwell(dwell_b), .out(out_b), .out_valid(out_valid_b),
        .idx(idx_b), .wrap(wrap_b)
    );

    typedef struct {
        logic       en;
        logic       mode;
        logic       load;
        logic [2:0] in;
        logic [7:0] dwell;
        logic [7:0] e_out;
        logic       e_vld;
        logic [2:0] e_idx;
        logic       e_wrap;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string name, input logic [7:0] e_out, input logic e_vld,
                           input logic [2:0] e_idx, input logic e_wrap);
        check({name, ".out"},  {24'd0, out}, {24'd0, e_out});
        check({name, ".vld"},  {31'd0, out_valid}, {31'd0, e_vld});
        check({name, ".idx"},  {29'd0, idx}, {29'd0, e_idx});
        check({name, ".wrap"}, {31'd0, wrap}, {31'd0, e_wrap});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; mode = 0; load = 0; in = 0; dwell = 0;
        en_b = 0; mode_b = 0; load_b = 0; in_b = 0; dwell_b = 0;

        //         en mode load in dwell  out     vld idx wrap
        vecs[0]  = '{1, 0, 1, 3'd5, 8'd0, 8'h20, 1, 3'd5, 0};
        vecs[1]  = '{1, 0, 0, 3'd2, 8'd0, 8'h20, 1, 3'd5, 0};
        vecs[2]  = '{1, 0, 1, 3'd3, 8'd0, 8'h08, 1, 3'd3, 0};
        vecs[3]  = '{0, 0, 1, 3'd6, 8'd0, 8'h00, 0, 3'd3, 0};
        vecs[4]  = '{0, 1, 1, 3'd6, 8'd0, 8'h00, 0, 3'd3, 0};
        vecs[5]  = '{1, 0, 0, 3'd6, 8'd0, 8'h00, 0, 3'd3, 0};
        vecs[6]  = '{1, 1, 0, 3'd6, 8'd2, 8'h40, 1, 3'd6, 0};
        vecs[7]  = '{1, 1, 0, 3'd6, 8'd2, 8'h40, 1, 3'd6, 0};
        vecs[8]  = '{1, 1, 0, 3'd6, 8'd2, 8'h40, 1, 3'd6, 0};
        vecs[9]  = '{1, 1, 0, 3'd6, 8'd2, 8'h80, 1, 3'd7, 0};
        vecs[10] = '{1, 1, 0, 3'd6, 8'd2, 8'h80, 1, 3'd7, 0};
        vecs[11] = '{1, 1, 0, 3'd6, 8'd2, 8'h80, 1, 3'd7, 0};
        vecs[12] = '{1, 1, 0, 3'd6, 8'd2, 8'h01, 1, 3'd0, 1};
        vecs[13] = '{1, 1, 0, 3'd6, 8'd2, 8'h01, 1, 3'd0, 0};
        vecs[14] = '{1, 1, 0, 3'd6, 8'd2, 8'h01, 1, 3'd0, 0};
        vecs[15] = '{1, 1, 0, 3'd6, 8'd2, 8'h02, 1, 3'd1, 0};
        vecs[16] = '{1, 0, 1, 3'd2, 8'd2, 8'h04, 1, 3'd2, 0};
        vecs[17] = '{1, 1, 0, 3'd5, 8'd0, 8'h20, 1, 3'd5, 0};
        vecs[18] = '{1, 1, 1, 3'd3, 8'd0, 8'h40, 1, 3'd6, 0};
        vecs[19] = '{1, 0, 0, 3'd3, 8'd0, 8'h00, 0, 3'd6, 0};
        vecs[20] = '{1, 1, 0, 3'd7, 8'd0, 8'h80, 1, 3'd7, 0};
        vecs[21] = '{1, 1, 0, 3'd7, 8'd0, 8'h01, 1, 3'd0, 1};

        repeat (2) @(posedge clk);
        #1;
        check_a("reset", 8'h00, 0, 3'd0, 0);
        check("reset_b.out", {16'd0, out_b}, 32'd0);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            en = vecs[i].en; mode = vecs[i].mode; load = vecs[i].load;
            in = vecs[i].in; dwell = vecs[i].dwell;
            step();
            check_a($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_vld,
                    vecs[i].e_idx, vecs[i].e_wrap);
        end

        // Direct load from SCAN, then hold for 20 cycles with load low.
        en = 1; mode = 0; load = 1; in = 3'd5;
        step();
        check_a("hold_load", 8'h20, 1, 3'd5, 0);
        load = 0; in = 3'd1;
        for (int k = 0; k < 20; k++) begin
            step();
            check_a($sformatf("hold%0d", k), 8'h20, 1, 3'd5, 0);
        end

        // Asynchronous reset between edges while scanning.
        mode = 1; in = 3'd6; dwell = 8'd3;
        repeat (3) step();
        check_a("pre_rst", 8'h40, 1, 3'd6, 0);
        #2 rst_n = 1'b0;
        #1;
        check_a("async_rst", 8'h00, 0, 3'd0, 0);
        en = 0; mode = 0;
        step();
        check_a("rst_held", 8'h00, 0, 3'd0, 0);
        #2 rst_n = 1'b1;
        step();
        check_a("rst_rel", 8'h00, 0, 3'd0, 0);

        // IN_W=4, dwell=0: one line per cycle, wrap every 16 cycles.
        en_b = 1; mode_b = 1; in_b = 4'd0; dwell_b = 8'd0;
        for (int k = 0; k < 40; k++) begin
            logic [3:0]  e_i;
            logic [15:0] e_o;
            e_i = 4'(k % 16);
            e_o = 16'd1 << e_i;
            step();
            check($sformatf("sweep%0d.idx", k), {28'd0, idx_b}, {28'd0, e_i});
            check($sformatf("sweep%0d.out", k), {16'd0, out_b}, {16'd0, e_o});
            check($sformatf("sweep%0d.wrap", k), {31'd0, wrap_b},
                  {31'd0, (k > 0) && (k % 16 == 0)});
        end
        en_b = 0;
        step();
        check("sweep_off.vld", {31'd0, out_valid_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
